// File: rtl/lsu_dmem_port_if.sv
// Request/response and data-memory signals of the load/store unit.
// The slave modport is the LSU's view; the master modport is the view of the
// execute stage and the memory it drives.
interface lsu_dmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_illegal;
  logic        dmwr_req;
  logic [3:0]  dmwr_mask;
  logic [31:0] dmdata_in;
  logic [31:0] dmdata_out;
  logic [31:0] dmaddr;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, dmdata_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_illegal,
    output dmwr_req, dmwr_mask, dmdata_in, dmaddr
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, dmdata_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_illegal,
    input  dmwr_req, dmwr_mask, dmdata_in, dmaddr
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// RV32I load/store unit in front of a word-addressed data memory.
// One request at a time: IDLE accepts, ACCESS drives memory, RESP strobes the
// result. Faulting requests skip ACCESS and never touch the memory outputs.
module lsu_dmem_port #(
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  lsu_dmem_port_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, fault, req_illegal, req_misal, access_done;
  logic        store_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  off_p0;
  logic        dmwr_req_q;
  logic [3:0]  dmwr_mask_q;
  logic [31:0] dmdata_in_q, dmaddr_q;
  logic        rsp_valid_q, rsp_mis_q, rsp_ill_q;
  logic [31:0] rsp_rdata_q;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = rd >> {off, 3'b000};
    h = rd >> {off[1], 4'b0000};
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'h0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'h0, h[15:0]};
      default: return rd;
    endcase
  endfunction

  assign accept      = bus.req_valid && (state_q == IDLE);
  assign fault       = req_illegal || req_misal;
  assign access_done = (state_q == ACCESS) && (state_d == RESP);

  // Request decode: illegal funct3 wins over misalignment.
  always_comb begin
    if (bus.req_store)
      req_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    req_misal = !req_illegal &&
                (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
  end

  // State and load-latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: stores stay one ACCESS cycle, loads count down MEM_LATENCY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = fault ? RESP : ACCESS;
          cnt_d   = LAT_M1;
        end
      end
      ACCESS: begin
        if (store_p0 || (cnt_q == 4'd0)) state_d = RESP;
        else                             cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request kind captured on accept; steers the ACCESS length.
  always_ff @(posedge clk) begin
    if (rst)         store_p0 <= 1'b0;
    else if (accept) store_p0 <= bus.req_store;
  end

  // Load-extraction fields captured on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_p0 <= bus.req_funct3;
      off_p0    <= bus.req_addr[1:0];
    end
  end

  // Memory-side outputs: loaded on a legal accept, write strobe lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmwr_req_q  <= 1'b0;
      dmwr_mask_q <= 4'h0;
      dmdata_in_q <= 32'h0;
      dmaddr_q    <= 32'h0;
    end else begin
      dmwr_req_q <= 1'b0;
      if (accept && !fault) begin
        dmaddr_q <= {2'b00, bus.req_addr[31:2]};
        if (bus.req_store) begin
          dmwr_req_q  <= 1'b1;
          dmwr_mask_q <= store_mask(bus.req_funct3, bus.req_addr[1:0]);
          dmdata_in_q <= store_data(bus.req_funct3, bus.req_wdata);
        end
      end
    end
  end

  // Response strobe: set entering RESP, cleared on every other cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
      if (accept && fault) begin
        rsp_valid_q <= 1'b1;
        rsp_mis_q   <= req_misal;
        rsp_ill_q   <= req_illegal;
      end else if (access_done) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= store_p0 ? 32'h0 : load_ext(bus.dmdata_out, funct3_p0, off_p0);
      end
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.dmwr_req       = dmwr_req_q;
  assign bus.dmwr_mask      = dmwr_mask_q;
  assign bus.dmdata_in      = dmdata_in_q;
  assign bus.dmaddr         = dmaddr_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_illegal    = rsp_ill_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: one instance with MEM_LATENCY=1, one with 3.
// Expected responses are queued when a request is accepted and checked,
// including arrival cycle, when rsp_valid is seen.
module tb_lsu_dmem_port;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = 32'd0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];

  lsu_dmem_port_if bus_a ();
  lsu_dmem_port_if bus_b ();

  lsu_dmem_port #(.MEM_LATENCY(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  lsu_dmem_port #(.MEM_LATENCY(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Response monitors: every rsp_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.rsp_valid) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL rsp_a_unexpected got rdata=%h mis=%b ill=%b required no response",
                 bus_a.rsp_rdata, bus_a.rsp_misaligned, bus_a.rsp_illegal);
      end else begin
        e = q_a.pop_front();
        if ({bus_a.rsp_rdata, bus_a.rsp_misaligned, bus_a.rsp_illegal} !== {e.rdata, e.mis, e.ill}) begin
          failures++;
          $display("FAIL rsp_a_fields got %h/%b/%b required %h/%b/%b", bus_a.rsp_rdata,
                   bus_a.rsp_misaligned, bus_a.rsp_illegal, e.rdata, e.mis, e.ill);
        end
        checks++;
        if (cyc !== e.due) begin
          failures++;
          $display("FAIL rsp_a_cycle got %0d required %0d", cyc, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.rsp_valid) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL rsp_b_unexpected got rdata=%h required no response", bus_b.rsp_rdata);
      end else begin
        e = q_b.pop_front();
        if ({bus_b.rsp_rdata, bus_b.rsp_misaligned, bus_b.rsp_illegal} !== {e.rdata, e.mis, e.ill}) begin
          failures++;
          $display("FAIL rsp_b_fields got %h/%b/%b required %h/%b/%b", bus_b.rsp_rdata,
                   bus_b.rsp_misaligned, bus_b.rsp_illegal, e.rdata, e.mis, e.ill);
        end
        checks++;
        if (cyc !== e.due) begin
          failures++;
          $display("FAIL rsp_b_cycle got %0d required %0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

  // Present a request on bus_a (called just after a negedge) and hold it until
  // accepted; returns at the negedge right after the accepting edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                       input logic exp_ill, input int lat, input bit push);
    exp_t e;
    bit   got = 0;
    bus_a.req_valid  = 1'b1;
    bus_a.req_store  = st;
    bus_a.req_funct3 = f3;
    bus_a.req_addr   = a;
    bus_a.req_wdata  = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus_a.req_ready) begin
        got     = 1;
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        e.ill   = exp_ill;
        e.due   = cyc + 32'd1 + 32'(lat);
        if (push) q_a.push_back(e);
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL issue_accept got no accept required accept within 40 cycles");
    end
  endtask

  task automatic drop();
    bus_a.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_a.size() != 0; i++) @(negedge clk);
    checks++;
    if (q_a.size() != 0) begin
      failures++;
      $display("FAIL drain_a got %0d pending required 0", q_a.size());
      q_a.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks += 8;
    if (bus_a.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b required 1", bus_a.req_ready); end
    if (bus_a.dmwr_req !== 1'b0) begin failures++; $display("FAIL reset_dmwr_req got %b required 0", bus_a.dmwr_req); end
    if (bus_a.dmwr_mask !== 4'h0) begin failures++; $display("FAIL reset_mask got %h required 0", bus_a.dmwr_mask); end
    if (bus_a.dmdata_in !== 32'h0) begin failures++; $display("FAIL reset_din got %h required 0", bus_a.dmdata_in); end
    if (bus_a.dmaddr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h required 0", bus_a.dmaddr); end
    if (bus_a.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b required 0", bus_a.rsp_valid); end
    if (bus_a.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got %h required 0", bus_a.rsp_rdata); end
    if (bus_b.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_b got %b required 1", bus_b.req_ready); end
  endtask

  task automatic test_store();
    logic [2:0]  f3 [3] = '{3'b010, 3'b000, 3'b001};
    logic [31:0] ad [3] = '{32'h10, 32'h13, 32'h12};
    logic [31:0] wd [3] = '{32'hDEADBEEF, 32'h000000A5, 32'h1234BEEF};
    logic [3:0]  mk [3] = '{4'hF, 4'b1000, 4'b1100};
    logic [31:0] dd [3] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hBEEFBEEF};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3[i], ad[i], wd[i], 32'h0, 1'b0, 1'b0, 1, 1'b1);
      drop();
      checks += 4;
      if (bus_a.dmwr_req !== 1'b1) begin failures++; $display("FAIL store%0d_req got %b required 1", i, bus_a.dmwr_req); end
      if (bus_a.dmwr_mask !== mk[i]) begin failures++; $display("FAIL store%0d_mask got %h required %h", i, bus_a.dmwr_mask, mk[i]); end
      if (bus_a.dmaddr !== 32'h4) begin failures++; $display("FAIL store%0d_addr got %h required 4", i, bus_a.dmaddr); end
      if (bus_a.dmdata_in !== dd[i]) begin failures++; $display("FAIL store%0d_data got %h required %h", i, bus_a.dmdata_in, dd[i]); end
      @(negedge clk);
      checks++;
      if (bus_a.dmwr_req !== 1'b0) begin failures++; $display("FAIL store%0d_req_off got %b required 0", i, bus_a.dmwr_req); end
      drain();
    end
  endtask

  task automatic test_load();
    logic [31:0] d;
    logic [7:0]  by;
    logic [15:0] hw;
    bus_a.dmdata_out = 32'h0080_0000;
    issue(1'b0, 3'b000, 32'h2, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 1, 1'b1);
    drop();
    checks += 2;
    if (bus_a.dmaddr !== 32'h0) begin failures++; $display("FAIL lb_addr got %h required 0", bus_a.dmaddr); end
    if (bus_a.dmwr_req !== 1'b0) begin failures++; $display("FAIL lb_req got %b required 0", bus_a.dmwr_req); end
    drain();
    issue(1'b0, 3'b100, 32'h2, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
    bus_a.dmdata_out = 32'h8001_0000;
    issue(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
    issue(1'b0, 3'b101, 32'h2, 32'h0, 32'h0000_8001, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
    bus_a.dmdata_out = 32'h1234_5678;
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1, 1'b1); drop();
    checks++;
    if (bus_a.dmaddr !== 32'h2) begin failures++; $display("FAIL lw_addr got %h required 2", bus_a.dmaddr); end
    drain();
    for (int off = 0; off < 4; off++) begin
      d  = $urandom;
      by = d[8*off +: 8];
      hw = d[16*(off/2) +: 16];
      bus_a.dmdata_out = d;
      issue(1'b0, 3'b000, 32'h100 + 32'(off), 32'h0, {{24{by[7]}}, by}, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
      issue(1'b0, 3'b100, 32'h100 + 32'(off), 32'h0, {24'h0, by}, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
      if (off % 2 == 0) begin
        issue(1'b0, 3'b001, 32'h100 + 32'(off), 32'h0, {{16{hw[15]}}, hw}, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
        issue(1'b0, 3'b101, 32'h100 + 32'(off), 32'h0, {16'h0, hw}, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
      end
    end
  endtask

  task automatic test_fault();
    logic        st [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [7] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b111, 3'b001};
    logic [31:0] ad [7] = '{32'h3, 32'h2, 32'h0, 32'h0, 32'h0, 32'h3, 32'h1};
    logic        mi [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        il [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    issue(1'b1, 3'b010, 32'h20, 32'h55AA55AA, 32'h0, 1'b0, 1'b0, 1, 1'b1); drop(); drain();
    for (int i = 0; i < 7; i++) begin
      issue(st[i], f3[i], ad[i], 32'hFFFF_FFFF, 32'h0, mi[i], il[i], 0, 1'b1);
      drop();
      checks++;
      if (bus_a.dmwr_req !== 1'b0) begin failures++; $display("FAIL fault%0d_req got %b required 0", i, bus_a.dmwr_req); end
      @(negedge clk);
      checks += 4;
      if (bus_a.dmwr_req !== 1'b0) begin failures++; $display("FAIL fault%0d_req2 got %b required 0", i, bus_a.dmwr_req); end
      if (bus_a.dmaddr !== 32'h8) begin failures++; $display("FAIL fault%0d_addr got %h required 8", i, bus_a.dmaddr); end
      if (bus_a.dmwr_mask !== 4'hF) begin failures++; $display("FAIL fault%0d_mask got %h required f", i, bus_a.dmwr_mask); end
      if (bus_a.dmdata_in !== 32'h55AA55AA) begin failures++; $display("FAIL fault%0d_data got %h required 55aa55aa", i, bus_a.dmdata_in); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    bus_a.dmdata_out = 32'hCAFE_F00D;
    issue(1'b1, 3'b010, 32'h40, 32'h0BAD_CAFE, 32'h0, 1'b0, 1'b0, 1, 1'b1);
    issue(1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1, 1'b1);
    issue(1'b0, 3'b001, 32'h45, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    issue(1'b0, 3'b100, 32'h47, 32'h0, 32'h0000_00CA, 1'b0, 1'b0, 1, 1'b1);
    drop();
    drain();
  endtask

  task automatic test_latency3();
    exp_t e;
    bus_b.dmdata_out = 32'hAAAA_AAAA;
    bus_b.req_valid  = 1'b1;
    bus_b.req_store  = 1'b0;
    bus_b.req_funct3 = 3'b010;
    bus_b.req_addr   = 32'h8;
    bus_b.req_wdata  = 32'h0;
    checks++;
    if (bus_b.req_ready !== 1'b1) begin failures++; $display("FAIL lat3_ready got %b required 1", bus_b.req_ready); end
    e.rdata = 32'h1234_5678; e.mis = 1'b0; e.ill = 1'b0; e.due = cyc + 32'd4;
    q_b.push_back(e);
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    checks += 2;
    if (bus_b.dmaddr !== 32'h2) begin failures++; $display("FAIL lat3_addr got %h required 2", bus_b.dmaddr); end
    if (bus_b.req_ready !== 1'b0) begin failures++; $display("FAIL lat3_busy got %b required 0", bus_b.req_ready); end
    repeat (2) @(negedge clk);
    bus_b.dmdata_out = 32'h1234_5678;
    for (int i = 0; i < 20 && q_b.size() != 0; i++) @(negedge clk);
    checks++;
    if (q_b.size() != 0) begin failures++; $display("FAIL drain_b got %0d pending required 0", q_b.size()); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 3'b010, 32'h30, 32'h0102_0304, 32'h0, 1'b0, 1'b0, 1, 1'b0);
    drop();
    checks++;
    if (bus_a.dmwr_req !== 1'b1) begin failures++; $display("FAIL rmid_req_on got %b required 1", bus_a.dmwr_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (bus_a.dmwr_req !== 1'b0) begin failures++; $display("FAIL rmid_req_off got %b required 0", bus_a.dmwr_req); end
    if (bus_a.rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rsp got %b required 0", bus_a.rsp_valid); end
    if (bus_a.dmaddr !== 32'h0) begin failures++; $display("FAIL rmid_addr got %h required 0", bus_a.dmaddr); end
    @(negedge clk);
    checks++;
    if (bus_a.req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got %b required 1", bus_a.req_ready); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_store = 1'b0; bus_a.req_funct3 = 3'b0;
    bus_a.req_addr = 32'h0; bus_a.req_wdata = 32'h0; bus_a.dmdata_out = 32'h0;
    bus_b.req_valid = 1'b0; bus_b.req_store = 1'b0; bus_b.req_funct3 = 3'b0;
    bus_b.req_addr = 32'h0; bus_b.req_wdata = 32'h0; bus_b.dmdata_out = 32'h0;
    test_reset();
    @(negedge clk);
    test_store();
    test_load();
    test_fault();
    test_back_to_back();
    test_latency3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
